// File: rtl/fmadd_mul_prenorm_pkg.sv
// -----------------------------------------------------------------------------
// fmadd_mul_prenorm_pkg
// Shared definitions for the half-precision multiplier front end:
// binary16 field widths, exponent bias, layout of the unrounded result
// bundle, canonical NaN/infinity significands and FSM state encoding.
// -----------------------------------------------------------------------------
package fmadd_mul_prenorm_pkg;

  // MSB indices of the binary16 fields
  localparam int STD  = 15;             // packed operand MSB
  localparam int MAN  = 9;              // stored fraction MSB
  localparam int EXP  = 4;              // exponent field MSB
  localparam int BIAS = 15;

  localparam int SIG_W = 2 * (MAN + 2); // 22-bit exact significand product
  localparam int NO_W  = MAN + MAN + EXP + 6; // 28-bit result bundle

  // Result bundle bit positions
  localparam int NO_SIGN   = NO_W - 1;
  localparam int NO_EXP_HI = NO_W - 2;
  localparam int NO_EXP_LO = SIG_W;

  localparam logic [EXP:0]     EXP_ALL1 = '1;
  localparam logic [SIG_W-1:0] SIG_NAN  = 22'h300000;
  localparam logic [SIG_W-1:0] SIG_INF  = 22'h200000;

  // Denormalizing right shifts never exceed this many cycles
  localparam int MAX_RSHIFT = 24;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_NORM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic             sign;
    logic [EXP:0]     exp;
    logic [SIG_W-1:0] sig;
  } bundle_t;

  // Denormals share the exponent of the smallest normal
  function automatic logic [EXP:0] eff_exp(input logic [EXP:0] field);
    return (field == '0) ? EXP'(1) + 1'b0 : field;
  endfunction

endpackage

// File: rtl/fmadd_mul_prenorm_if.sv
// -----------------------------------------------------------------------------
// fmadd_mul_prenorm_if
// Operand handshake (in_*) and result handshake (out_*) of the multiplier
// front end.
//   master : drives operands, consumes results (upstream + rounding stage)
//   slave  : the multiplier front end itself
// -----------------------------------------------------------------------------
interface fmadd_mul_prenorm_if;
  import fmadd_mul_prenorm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [STD:0]    in_a;
  logic [STD:0]    in_b;
  logic            out_valid;
  logic            out_ready;
  logic [NO_W-1:0] out_no;
  logic            out_overflow;
  logic            out_sticky_pn;
  logic            out_invalid;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_no, out_overflow, out_sticky_pn, out_invalid
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_no, out_overflow, out_sticky_pn, out_invalid
  );
endinterface

// File: rtl/fmadd_mul_seq_core.sv
// -----------------------------------------------------------------------------
// fmadd_mul_seq_core
// Radix-2, MSB-first shift-add multiplier for two 11-bit significands.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands (one cycle)
//   mcand      : multiplicand
//   mplier     : multiplier
//   done       : high during the 11th compute cycle
//   product    : exact product, valid while done is high
// The product is presented combinationally in the final cycle so the owner
// can capture it on the same edge that retires the last partial product.
// -----------------------------------------------------------------------------
module fmadd_mul_seq_core
  import fmadd_mul_prenorm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAN+1:0]   mcand,
  input  logic [MAN+1:0]   mplier,
  output logic             done,
  output logic [SIG_W-1:0] product
);

  logic [3:0]       cnt_reg;
  logic             busy_reg;
  logic [MAN+1:0]   mcand_reg;
  logic [MAN+1:0]   mplier_reg;
  logic [SIG_W-1:0] acc_reg;
  logic [SIG_W-1:0] acc_next;

  assign acc_next = {acc_reg[SIG_W-2:0], 1'b0}
                  + (mplier_reg[cnt_reg] ? {{(SIG_W-MAN-2){1'b0}}, mcand_reg} : '0);
  assign done     = busy_reg && (cnt_reg == 4'd0);
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= 4'd0;
      busy_reg   <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      cnt_reg    <= 4'(MAN + 1);
      busy_reg   <= 1'b1;
      mcand_reg  <= mcand;
      mplier_reg <= mplier;
      acc_reg    <= '0;
    end else if (busy_reg) begin
      acc_reg <= acc_next;
      if (cnt_reg == 4'd0) busy_reg <= 1'b0;
      else                 cnt_reg  <= cnt_reg - 4'd1;
    end
  end

endmodule

// File: rtl/fmadd_mul_prenorm.sv
// -----------------------------------------------------------------------------
// fmadd_mul_prenorm
// Iterative binary16 multiplier front end: exact significand product,
// normalization/denormalization, unrounded {sign, exp, sig} bundle out.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fmadd_mul_prenorm_if
//                in_valid/in_ready/in_a/in_b  operand handshake
//                out_valid/out_ready/out_no   result handshake
//                out_overflow, out_sticky_pn, out_invalid  result flags
// Single entry: a new operand pair is taken only in IDLE.
// -----------------------------------------------------------------------------
module fmadd_mul_prenorm
  import fmadd_mul_prenorm_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  fmadd_mul_prenorm_if.slave bus
);

  logic [1:0]        state_reg;
  logic              sign_reg;
  logic signed [7:0] e_reg;
  logic [SIG_W-1:0]  p_reg;
  logic              sticky_reg;
  logic [4:0]        rshift_cnt_reg;
  logic [NO_W-1:0]   out_no_reg;
  logic              out_overflow_reg;
  logic              out_sticky_reg;
  logic              out_invalid_reg;

  // Per-operand classification: index 0 is A, index 1 is B
  logic [1:0][STD:0]   op;
  logic [1:0]          is_zero, is_inf, is_nan, is_snan;
  logic [1:0][EXP:0]   eff;
  logic [1:0][MAN+1:0] sig;

  assign op[0] = bus.in_a;
  assign op[1] = bus.in_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_decode
    logic [EXP:0] field;
    logic [MAN:0] frac;
    assign field       = op[gi][STD-1:MAN+1];
    assign frac        = op[gi][MAN:0];
    assign is_zero[gi] = (field == '0) && (frac == '0);
    assign is_inf[gi]  = (field == EXP_ALL1) && (frac == '0);
    assign is_nan[gi]  = (field == EXP_ALL1) && (frac != '0);
    assign is_snan[gi] = is_nan[gi] && !frac[MAN];
    assign eff[gi]     = eff_exp(field);
    assign sig[gi]     = {field != '0, frac};
  end

  logic              sign_in;
  logic              inf_x_zero;
  logic              special;
  logic              special_inv;
  bundle_t           special_no;
  logic signed [7:0] e_calc;
  logic              core_start;
  logic              core_done;
  logic [SIG_W-1:0]  core_product;

  assign sign_in    = op[0][STD] ^ op[1][STD];
  assign inf_x_zero = (is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0]);
  assign special    = |is_zero || |is_inf || |is_nan;
  assign special_inv = inf_x_zero || |is_snan;
  // E = ea + eb - bias + 1, so P'/2^21 * 2^(E-bias) is the exact product
  assign e_calc     = $signed({3'b000, eff[0]}) + $signed({3'b000, eff[1]})
                    - $signed(8'(BIAS - 1));

  always_comb begin
    special_no = '0;
    if (|is_nan || inf_x_zero) begin
      special_no.sign = 1'b0;
      special_no.exp  = EXP_ALL1;
      special_no.sig  = SIG_NAN;
    end else if (|is_inf) begin
      special_no.sign = sign_in;
      special_no.exp  = EXP_ALL1;
      special_no.sig  = SIG_INF;
    end else begin
      special_no.sign = sign_in;
    end
  end

  assign core_start = (state_reg == ST_IDLE) && bus.in_valid && !special;

  fmadd_mul_seq_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (core_start),
    .mcand   (sig[0]),
    .mplier  (sig[1]),
    .done    (core_done),
    .product (core_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      sign_reg         <= 1'b0;
      e_reg            <= '0;
      p_reg            <= '0;
      sticky_reg       <= 1'b0;
      rshift_cnt_reg   <= '0;
      out_no_reg       <= '0;
      out_overflow_reg <= 1'b0;
      out_sticky_reg   <= 1'b0;
      out_invalid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.in_valid) begin
          sign_reg <= sign_in;
          e_reg    <= e_calc;
          if (special) begin
            out_no_reg       <= special_no;
            out_overflow_reg <= 1'b0;
            out_sticky_reg   <= 1'b0;
            out_invalid_reg  <= special_inv;
            state_reg        <= ST_DONE;
          end else begin
            state_reg <= ST_MUL;
          end
        end
        ST_MUL: if (core_done) begin
          p_reg          <= core_product;
          sticky_reg     <= 1'b0;
          rshift_cnt_reg <= '0;
          state_reg      <= ST_NORM;
        end
        ST_NORM: begin
          if (!p_reg[SIG_W-1] && (e_reg > 8'sd1)) begin
            p_reg <= {p_reg[SIG_W-2:0], 1'b0};
            e_reg <= e_reg - 8'sd1;
          end else if ((e_reg < 8'sd1) && (rshift_cnt_reg < 5'(MAX_RSHIFT))) begin
            p_reg          <= {1'b0, p_reg[SIG_W-1:1]};
            sticky_reg     <= sticky_reg | p_reg[0];
            e_reg          <= e_reg + 8'sd1;
            rshift_cnt_reg <= rshift_cnt_reg + 5'd1;
          end else begin
            out_sticky_reg  <= sticky_reg;
            out_invalid_reg <= 1'b0;
            if (e_reg >= 8'sd31) begin
              out_overflow_reg <= 1'b1;
              out_no_reg       <= {sign_reg, EXP_ALL1, {SIG_W{1'b0}}};
            end else begin
              out_overflow_reg <= 1'b0;
              // Exponent field is 0 when the value stayed subnormal
              out_no_reg <= {sign_reg, p_reg[SIG_W-1] ? e_reg[EXP:0] : {(EXP+1){1'b0}}, p_reg};
            end
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: if (bus.out_ready) state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state_reg == ST_IDLE);
  assign bus.out_valid     = (state_reg == ST_DONE);
  assign bus.out_no        = out_no_reg;
  assign bus.out_overflow  = out_overflow_reg;
  assign bus.out_sticky_pn = out_sticky_reg;
  assign bus.out_invalid   = out_invalid_reg;

endmodule

// File: tb/tb_fmadd_mul_prenorm.sv
// -----------------------------------------------------------------------------
// tb_fmadd_mul_prenorm
// Directed and random binary16 operand pairs against an arithmetic reference
// model; checks result bundle, flags, latency, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_fmadd_mul_prenorm;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  fmadd_mul_prenorm_if bus ();

  fmadd_mul_prenorm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Exact product value P/2^20 * 2^(ea+eb-30), placed on a 22-bit grid whose
  // bit 21 weighs 2^(E-15), clamped to the subnormal range.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                    output logic [27:0] no, output logic ovf,
                                    output logic stk, output logic inv, output int lat);
    int     fa, fb, ma, mb, ea, eb, e, sh, msb;
    longint p;
    logic   sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, ixz;
    fa = int'(a[14:10]); fb = int'(b[14:10]);
    a_nan  = (fa == 31) && (a[9:0] != 0);  b_nan  = (fb == 31) && (b[9:0] != 0);
    a_inf  = (fa == 31) && (a[9:0] == 0);  b_inf  = (fb == 31) && (b[9:0] == 0);
    a_zero = (fa == 0)  && (a[9:0] == 0);  b_zero = (fb == 0)  && (b[9:0] == 0);
    ixz = (a_inf && b_zero) || (b_inf && a_zero);
    sgn = a[15] ^ b[15];
    ovf = 1'b0; stk = 1'b0; inv = 1'b0; lat = 1;
    if (a_nan || b_nan || ixz) begin
      no  = {1'b0, 5'h1F, 22'h300000};
      inv = ixz || (a_nan && !a[9]) || (b_nan && !b[9]);
    end else if (a_inf || b_inf) begin
      no = {sgn, 5'h1F, 22'h200000};
    end else if (a_zero || b_zero) begin
      no = {sgn, 27'd0};
    end else begin
      ma = (fa != 0 ? 1024 : 0) + int'(a[9:0]);
      mb = (fb != 0 ? 1024 : 0) + int'(b[9:0]);
      ea = (fa == 0) ? 1 : fa;
      eb = (fb == 0) ? 1 : fb;
      p  = longint'(ma) * longint'(mb);
      e  = ea + eb - 15 + 1;
      if (e < 1) begin
        sh  = 1 - e;
        if (sh > 24) sh = 24;
        stk = (p & ((64'(1) << sh) - 1)) != 0;
        p   = p >> sh;
        e   = e + sh;
      end else begin
        msb = 0;
        for (int i = 0; i < 22; i++) if (p[i]) msb = i;
        sh = 21 - msb;
        if (sh > e - 1) sh = e - 1;
        p = p << sh;
        e = e - sh;
      end
      lat = 11 + sh + 2;
      if (e >= 31) begin
        ovf = 1'b1;
        no  = {sgn, 5'h1F, 22'd0};
      end else begin
        no = {sgn, (p[21] ? 5'(e) : 5'd0), 22'(p)};
      end
    end
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [27:0] e_no;
    logic        e_ovf, e_stk, e_inv;
    int          e_lat, cycles;
    logic [27:0] held;
    ref_model(a, b, e_no, e_ovf, e_stk, e_inv, e_lat);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = 16'h0;
    bus.in_b     = 16'h0;
    check("in_ready_busy", bus.in_ready, 1'b0);
    cycles = 1;
    while (!bus.out_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("out_valid", bus.out_valid, 1'b1);
    check("latency", 64'(cycles), 64'(e_lat));
    check("out_no", bus.out_no, e_no);
    check("overflow", bus.out_overflow, e_ovf);
    check("sticky_pn", bus.out_sticky_pn, e_stk);
    check("invalid", bus.out_invalid, e_inv);
    $display("op a=%h b=%h no=%h ovf=%b stk=%b inv=%b lat=%0d exp_no=%h exp_lat=%0d",
             a, b, bus.out_no, bus.out_overflow, bus.out_sticky_pn, bus.out_invalid,
             cycles, e_no, e_lat);
    if (hold > 0) begin
      held = bus.out_no;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bp_stable", bus.out_no, held);
        check("bp_valid", bus.out_valid, 1'b1);
        check("bp_in_ready", bus.in_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("valid_drop", bus.out_valid, 1'b0);
    check("ready_back", bus.in_ready, 1'b1);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'h0;
    bus.in_b      = 16'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_no", bus.out_no, 28'd0);
    check("rst_overflow", bus.out_overflow, 1'b0);
    check("rst_sticky", bus.out_sticky_pn, 1'b0);
    check("rst_invalid", bus.out_invalid, 1'b0);
    rst_n = 1'b1;

    run_op(16'h3C00, 16'h3C00, 0);   // 1.0 x 1.0
    run_op(16'h4000, 16'h4200, 0);   // 2.0 x 3.0
    run_op(16'h7800, 16'h7800, 0);   // overflow
    run_op(16'h0400, 16'h3800, 0);   // subnormal result, exact
    run_op(16'h0001, 16'h3400, 0);   // tiny subnormal result
    run_op(16'h7C00, 16'h0000, 0);   // inf x 0
    run_op(16'hBC00, 16'h0000, 0);   // -1 x 0
    run_op(16'h7D00, 16'h3C00, 0);   // sNaN
    run_op(16'h7E00, 16'h3C00, 0);   // qNaN
    run_op(16'hFC00, 16'h4000, 0);   // -inf x 2
    run_op(16'h03FF, 16'h03FF, 0);   // subnormal x subnormal, deepest shift
    run_op(16'h0001, 16'h7BFF, 0);   // subnormal x large, many left shifts
    run_op(16'h4000, 16'h4200, 5);   // backpressure

    // Reset in the middle of MUL discards the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h3C00;
    bus.in_b     = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h3E00, 16'hC100, 0);   // 1.5 x -2.5 after reset

    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
